// File: rtl/skylark_pkg.sv
// Shared types and constants for the register-file write path.
package skylark_pkg;

  localparam int RF_XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [4:0]         addr;
    logic [RF_XLEN-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_wr_queue.sv
// In-order pending-write buffer: dual enqueue (older slot first), single dequeue,
// occupancy count and a youngest-match search for two lookup addresses.
module wr_queue
  import skylark_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enq0_v,
  input  logic [4:0]              i_enq0_a,
  input  logic [XLEN-1:0]         i_enq0_d,
  input  logic                    i_enq1_v,
  input  logic [4:0]              i_enq1_a,
  input  logic [XLEN-1:0]         i_enq1_d,
  input  logic                    i_deq,
  input  logic [4:0]              i_la1,
  input  logic [4:0]              i_la2,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [4:0]              o_head_a,
  output logic [XLEN-1:0]         o_head_d,
  output logic                    o_hit1,
  output logic [XLEN-1:0]         o_hd1,
  output logic                    o_hit2,
  output logic [XLEN-1:0]         o_hd2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_tail1;
  logic [PW-1:0]   w_idx;

  assign w_tail1  = r_tail + PW'(i_enq0_v);
  assign o_count  = r_count;
  assign o_head_a = r_addr[r_head];
  assign o_head_d = r_data[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(i_deq);
      r_tail  <= r_tail + PW'(i_enq0_v) + PW'(i_enq1_v);
      r_count <= r_count + CW'(i_enq0_v) + CW'(i_enq1_v) - CW'(i_deq);
    end
  end

  // Payload needs no reset: only slots inside [head, head+count) are ever read.
  always_ff @(posedge clk) begin
    if (i_enq0_v) begin
      r_addr[r_tail] <= i_enq0_a;
      r_data[r_tail] <= i_enq0_d;
    end
    if (i_enq1_v) begin
      r_addr[w_tail1] <= i_enq1_a;
      r_data[w_tail1] <= i_enq1_d;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    o_hit1 = 1'b0;
    o_hd1  = '0;
    o_hit2 = 1'b0;
    o_hd2  = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (CW'(i) < r_count) begin
        if (i_la1 != REG_X0 && r_addr[w_idx] == i_la1) begin
          o_hit1 = 1'b1;
          o_hd1  = r_data[w_idx];
        end
        if (i_la2 != REG_X0 && r_addr[w_idx] == i_la2) begin
          o_hit2 = 1'b1;
          o_hd2  = r_data[w_idx];
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between W2 (older) and W.
// Optional macro RF_WRITE_ARBITER_FWD_EN enables forwarding from the pending queue.
module rf_write_arbiter
  import skylark_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_w,
  input  logic [4:0]              a3_w,
  input  logic [XLEN-1:0]         wd_w,
  input  logic                    we_w2,
  input  logic [4:0]              a4_w2,
  input  logic [XLEN-1:0]         wd_w2,
  input  logic [4:0]              la1,
  input  logic [4:0]              la2,
  output logic                    rf_we,
  output logic [4:0]              rf_a,
  output logic [XLEN-1:0]         rf_wd,
  output logic                    hit1,
  output logic                    hit2,
  output logic [XLEN-1:0]         hd1,
  output logic [XLEN-1:0]         hd2,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            w_v1, w_v2, w_empty, w_deq;
  logic            w_cand1, w_cand2, w_acc1, w_acc2;
  logic [CW:0]     w_free, w_need;
  logic [CW-1:0]   w_count;
  logic            w_enq0_v, w_enq1_v;
  logic [4:0]      w_enq0_a;
  logic [XLEN-1:0] w_enq0_d;
  logic [4:0]      w_head_a;
  logic [XLEN-1:0] w_head_d;
  logic            w_qhit1, w_qhit2;
  logic [XLEN-1:0] w_qhd1, w_qhd2;
  logic            r_overflow;

  assign w_v1    = we_w  && (a3_w  != REG_X0);
  assign w_v2    = we_w2 && (a4_w2 != REG_X0);
  assign w_empty = (w_count == '0);
  assign w_deq   = !w_empty;

  // A non-empty queue owns the port, so every valid request queues behind it;
  // with an empty queue only W queues, and only when W2 took the port.
  assign w_cand2 = w_v2 && !w_empty;
  assign w_cand1 = w_v1 && (!w_empty || w_v2);

  assign w_free = (CW+1)'(DEPTH) - {1'b0, w_count} + {{CW{1'b0}}, w_deq};
  assign w_acc2 = w_cand2 && (w_free != '0);
  assign w_need = w_acc2 ? (CW+1)'(2) : (CW+1)'(1);
  assign w_acc1 = w_cand1 && (w_free >= w_need);

  assign w_enq0_v = w_acc2 || w_acc1;
  assign w_enq0_a = w_acc2 ? a4_w2 : a3_w;
  assign w_enq0_d = w_acc2 ? wd_w2 : wd_w;
  assign w_enq1_v = w_acc2 && w_acc1;

  wr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .i_enq0_v (w_enq0_v),
    .i_enq0_a (w_enq0_a),
    .i_enq0_d (w_enq0_d),
    .i_enq1_v (w_enq1_v),
    .i_enq1_a (a3_w),
    .i_enq1_d (wd_w),
    .i_deq    (w_deq),
    .i_la1    (la1),
    .i_la2    (la2),
    .o_count  (w_count),
    .o_head_a (w_head_a),
    .o_head_d (w_head_d),
    .o_hit1   (w_qhit1),
    .o_hd1    (w_qhd1),
    .o_hit2   (w_qhit2),
    .o_hd2    (w_qhd2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if ((w_cand1 && !w_acc1) || (w_cand2 && !w_acc2)) begin
      r_overflow <= 1'b1;
    end
  end

  // Port is gated during reset because requests may still be arriving.
  always_comb begin
    rf_we = 1'b0;
    rf_a  = REG_X0;
    rf_wd = '0;
    if (!reset) begin
      if (!w_empty) begin
        rf_we = 1'b1;
        rf_a  = w_head_a;
        rf_wd = w_head_d;
      end else if (w_v2) begin
        rf_we = 1'b1;
        rf_a  = a4_w2;
        rf_wd = wd_w2;
      end else if (w_v1) begin
        rf_we = 1'b1;
        rf_a  = a3_w;
        rf_wd = wd_w;
      end
    end
  end

  assign count        = w_count;
  assign overflow_err = r_overflow;

`ifdef RF_WRITE_ARBITER_FWD_EN
  assign hit1      = w_qhit1;
  assign hit2      = w_qhit2;
  assign hd1       = w_qhd1;
  assign hd2       = w_qhd2;
  assign stall_req = (w_count >= CW'(DEPTH-1));
`else
  // Without forwarding the pipeline waits for the queue to drain completely.
  logic w_unused_lookup;
  assign w_unused_lookup = ^{w_qhit1, w_qhit2, w_qhd1, w_qhd2};
  assign hit1      = 1'b0;
  assign hit2      = 1'b0;
  assign hd1       = '0;
  assign hd2       = '0;
  assign stall_req = (w_count != '0);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a queue-level reference model.
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic we_w = 0, we_w2 = 0;
  logic [4:0] a3_w = 0, a4_w2 = 0, la1 = 0, la2 = 0;
  logic [31:0] wd_w = 0, wd_w2 = 0;
  logic rf_we, hit1, hit2, stall_req, overflow_err;
  logic [4:0] rf_a;
  logic [31:0] rf_wd, hd1, hd2;
  logic [2:0] count;

  logic [36:0] exp_q[$];
  ent_t        mq[$];
  bit          m_ovf;
  int          tests = 0;
  int          fails = 0;

  logic        exp_chk = 0;
  logic        exp_we, exp_stall, exp_hit1, exp_hit2, exp_ovf;
  logic [31:0] exp_hd1, exp_hd2;
  int          exp_count;

  rf_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .we_w(we_w), .a3_w(a3_w), .wd_w(wd_w),
    .we_w2(we_w2), .a4_w2(a4_w2), .wd_w2(wd_w2),
    .la1(la1), .la2(la2),
    .rf_we(rf_we), .rf_a(rf_a), .rf_wd(rf_wd),
    .hit1(hit1), .hit2(hit2), .hd1(hd1), .hd2(hd2),
    .stall_req(stall_req), .count(count), .overflow_err(overflow_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus: drive, compute the model's view, push expectations.
  task automatic cycle(input bit ww, input logic [4:0] a3, input logic [31:0] d3,
                       input bit ww2, input logic [4:0] a4, input logic [31:0] d4,
                       input logic [4:0] l1, input logic [4:0] l2);
    ent_t all[$];
    ent_t e;
    @(posedge clk);
    #1;
    we_w = ww; a3_w = a3; wd_w = d3;
    we_w2 = ww2; a4_w2 = a4; wd_w2 = d4;
    la1 = l1; la2 = l2;

    exp_count = mq.size();
    exp_ovf   = m_ovf;
    exp_hit1 = 0; exp_hd1 = 0; exp_hit2 = 0; exp_hd2 = 0;
    foreach (mq[i]) begin
      if (l1 != 0 && mq[i].a == l1) begin exp_hit1 = 1; exp_hd1 = mq[i].d; end
      if (l2 != 0 && mq[i].a == l2) begin exp_hit2 = 1; exp_hd2 = mq[i].d; end
    end
`ifdef RF_WRITE_ARBITER_FWD_EN
    exp_stall = (mq.size() >= DEPTH-1);
`else
    exp_hit1 = 0; exp_hd1 = 0; exp_hit2 = 0; exp_hd2 = 0;
    exp_stall = (mq.size() != 0);
`endif

    // Program order: queued entries, then W2, then W; the oldest takes the port.
    all = mq;
    if (ww2 && a4 != 0) begin e.a = a4; e.d = d4; all.push_back(e); end
    if (ww  && a3 != 0) begin e.a = a3; e.d = d3; all.push_back(e); end
    exp_we = (all.size() != 0);
    if (all.size() != 0) begin
      e = all.pop_front();
      exp_q.push_back({e.a, e.d});
    end
    while (all.size() > DEPTH) begin
      void'(all.pop_back());
      m_ovf = 1;
    end
    mq = all;
    exp_chk = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [36:0] e;
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rf_write", {27'd0, rf_a, rf_wd}, {27'd0, e});
      end
    end
    if (exp_chk) begin
      check("rf_we", rf_we, exp_we);
      check("count", count, exp_count);
      check("stall_req", stall_req, exp_stall);
      check("hit1", hit1, exp_hit1);
      check("hd1", hd1, exp_hd1);
      check("hit2", hit2, exp_hit2);
      check("hd2", hd2, exp_hd2);
      check("overflow_err", overflow_err, exp_ovf);
      exp_chk = 0;
    end
  end

  initial begin
    bit ww, ww2;
    int p;
    // reset state while requests are active
    we_w = 1; a3_w = 5'd5; wd_w = 32'h55;
    #3;
    check("rst_rf_we", rf_we, 0);
    check("rst_count", count, 0);
    check("rst_stall", stall_req, 0);
    check("rst_overflow", overflow_err, 0);
    we_w = 0;
    @(negedge clk);
    reset = 0;

    cycle(1, 5'd5, 32'h11, 0, 0, 0, 0, 0);                 // single pass-through
    cycle(1, 5'd4, 32'hBB, 1, 5'd3, 32'hAA, 5'd4, 0);      // collision
    idle(2);
    cycle(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 5'd0, 0);        // x0 filter
    for (int i = 0; i < 5; i++)                            // fill, stall, overflow
      cycle(1, 5'(8 + 2*i), 32'h100 + i, 1, 5'(9 + 2*i), 32'h200 + i, 5'd8, 5'(9 + 2*i));
    idle(6);
    cycle(1, 5'd12, 32'h12, 1, 5'd9, 32'h9, 0, 0);         // youngest wins
    cycle(1, 5'd7, 32'h2, 1, 5'd7, 32'h1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
    idle(4);

    for (int n = 0; n < 800; n++) begin
      p = 20 + 20 * ((n / 100) % 4);
      ww  = ($urandom_range(0, 99) < p);
      ww2 = ($urandom_range(0, 99) < p);
      cycle(ww, 5'($urandom_range(0, 15)), $urandom, ww2, 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(6);

    // reset mid-operation with count = 3
    for (int i = 0; i < 3; i++) cycle(1, 5'(20 + i), 32'h300 + i, 1, 5'(24 + i), 32'h400 + i, 0, 0);
    cycle(1, 5'd28, 32'h500, 1, 5'd29, 32'h600, 5'd22, 0);
    @(negedge clk);
    #1;
    reset = 1;
    #1;
    check("midrst_count", count, 0);
    check("midrst_rf_we", rf_we, 0);
    check("midrst_stall", stall_req, 0);
    check("midrst_hit1", hit1, 0);
    mq.delete();
    exp_q.delete();
    m_ovf = 0;
    we_w = 0; we_w2 = 0;
    @(negedge clk);
    reset = 0;
    cycle(1, 5'd6, 32'h66, 0, 0, 0, 0, 0);
    idle(6);

    @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
